// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer: small FIFO feeding a two-state shifter.
// Define SEQ_SER_LSB_FIRST_EN to emit bit 0 first (default is MSB first).
module seq_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       ser_en,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic                       word_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [BW-1:0]    bit_cnt;
  logic             push;
  logic             pop;
  logic             last;
  logic             shifting;

  assign in_ready   = count < FULL;
  assign fifo_count = count;
  assign push       = in_valid && in_ready;
  assign shifting   = (state == SHIFT) && ser_en;
  assign last       = shifting && (bit_cnt == LAST);
  assign pop        = (count != '0) &&
                      ((state == IDLE) || last);

  assign bit_valid = (state == SHIFT);
  assign busy      = (state == SHIFT) || (count != '0);

`ifdef SEQ_SER_LSB_FIRST_EN
  assign bit_out   = sreg[0];
  assign sreg_next = sreg >> 1;
`else
  assign bit_out   = sreg[WIDTH-1];
  assign sreg_next = sreg << 1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // sreg is cleared on return to IDLE so bit_out reads 0 there
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= last;
      if (pop) begin
        state   <= SHIFT;
        sreg    <= mem[rd_ptr];
        bit_cnt <= '0;
      end else if (last) begin
        state   <= IDLE;
        sreg    <= '0;
        bit_cnt <= '0;
      end else if (shifting) begin
        sreg    <= sreg_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Upstream feeder for the sequence detector: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts them out one bit per enabled clock on a registered serial line that drives the detector's `d_in`. It lets the bench and system logic supply test patterns as bytes rather than hand-toggled bits, with gap-free back-to-back words and downstream stall support.

## Interface
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  rising-edge clock, single domain.
- `reset`  in  1  asynchronous, active-low reset; asserting (0) clears all state immediately.
- `in_data`  in  WIDTH  parallel word to serialize.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept; transfer occurs on a rising edge with `in_valid && in_ready`.
- `ser_en`  in  1  downstream advance enable; 0 stalls the shifter.
- `bit_out`  out  1  registered serial bit (connects to detector `d_in`).
- `bit_valid`  out  1  `bit_out` holds a real data bit.
- `word_done`  out  1  one-cycle pulse: last bit of a word consumed.
- `busy`  out  1  shifter active or FIFO non-empty.
- `fifo_count`  out  $clog2(DEPTH)+1  entries stored (0..DEPTH).

## Operation
- FIFO: circular, DEPTH×WIDTH, write/read pointers wrap modulo DEPTH. `in_ready = (fifo_count < DEPTH)`, combinational from registered count only; no bypass when full, even if a pop occurs the same cycle.
- Push and pop in the same cycle: `fifo_count` unchanged; both pointers advance.
- Shifter FSM, two states:
  - IDLE: `bit_valid=0`, `bit_out=0`. If `fifo_count≠0`, pop head into shift register, `bit_cnt←0`, go SHIFT. Load is independent of `ser_en`.
  - SHIFT: `bit_out` = current bit, `bit_valid=1`. On an edge with `ser_en=1`: if `bit_cnt<WIDTH-1`, shift one bit and `bit_cnt++`. If `bit_cnt==WIDTH-1`, pulse `word_done`; then, if FIFO is non-empty, pop the next word into the shifter with `bit_cnt←0` (no bubble), otherwise go to IDLE. With `ser_en=0`, all shifter state holds.
- Bit order: MSB first by default (see Configuration).
- `busy = (state==SHIFT) || (fifo_count≠0)`.
- Words accepted into the FIFO are never dropped or reordered.

## Timing
- Reset values: `in_ready=1`, `bit_out=0`, `bit_valid=0`, `word_done=0`, `busy=0`, `fifo_count=0`, FSM=IDLE, pointers=0.
- Reset mid-word: the in-flight word and all FIFO contents are discarded, and outputs go to reset values asynchronously. The first rising edge after reset is released behaves as IDLE with an empty FIFO.
- Latency: a word accepted at edge N into an empty, IDLE block is popped at edge N+1, so `bit_valid=1` with the first bit after N+1.
- Throughput: with `ser_en` held at 1 and the FIFO kept non-empty, each word occupies exactly WIDTH cycles and `bit_valid` stays continuously high.
- `word_done` is registered and is high in the cycle after the edge that consumed the last bit.
- `fifo_count` updates on the edge of the push/pop; `in_ready` follows in the same cycle.

## Configuration
- `SEQ_SER_LSB_FIRST_EN` defined: the shifter emits bit 0 first and shifts right.
- Not defined: the shifter emits bit WIDTH-1 first and shifts left.
- FIFO, handshake and timing are identical in both builds.

## Test plan
- Reset: hold `reset=0` mid-stream with 2 words queued → all outputs at reset values immediately. After release, `fifo_count=0`, `in_ready=1`, and no stale bits appear.
- Single word, default build: push 8'hB5 with `ser_en=1` → `bit_out` sequence 1,0,1,1,0,1,0,1. `bit_valid` high for exactly 8 cycles starting 2 cycles after the push. One `word_done` pulse follows, then `busy=0`.
- Back-to-back: push 8'hF0, 8'h0F, 8'hAA consecutively → 24 contiguous valid bits 11110000 00001111 10101010 and 3 `word_done` pulses spaced 8 cycles apart.
- Full/stall: hold `ser_en=0` and push until `in_ready=0` → the block accepts exactly DEPTH+1 words (4 in the FIFO plus 1 in the shifter) and `fifo_count=4`. `bit_out` stays frozen on the first bit. Releasing `ser_en` drains all 5 words in order.
- Stall mid-word: drop `ser_en` for 3 cycles after the 3rd bit of 8'hC3 → `bit_out` holds bit 3 and `bit_valid` stays 1. The sequence resumes unbroken: 1,1,0,0,0,0,1,1.
- LSB build (`SEQ_SER_LSB_FIRST_EN`): push 8'hB5 → `bit_out` sequence 1,0,1,0,1,1,0,1.
